// File: rtl/meta_package.sv
// Shared descriptor types and constants for the enqueue descriptor path.
package meta_package;

   localparam int unsigned ENQ_DEQ_BUF_DEPTH = 3;

   typedef struct packed {
      logic [15:0] pkt_ptr;
      logic [13:0] pkt_len;
      logic [7:0]  qid;
      logic [7:0]  flags;
   } enq_pkt_desc_type;

   typedef enum logic [1:0] {
      OccEmpty = 2'd0,
      OccOne   = 2'd1,
      OccTwo   = 2'd2,
      OccFull  = 2'd3
   } occ_e;

   // Pointer increment wrapping at the buffer depth (3 is not a power of two).
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(ENQ_DEQ_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/enq_pkt_desc_obuf.sv
// Three-entry output buffer: FIFO-ordered register store with a registered head descriptor.
module enq_pkt_desc_obuf
   import meta_package::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  enq_pkt_desc_type wr_data,
   input  logic             rd_ready,
   output logic             valid,
   output enq_pkt_desc_type head_data,
   output logic [1:0]       occ
);

   enq_pkt_desc_type mem_q [0:ENQ_DEQ_BUF_DEPTH-1];
   enq_pkt_desc_type head_data_q, head_data_d;
   logic [1:0]       head_q, head_d, tail_q, tail_d;
   occ_e             occ_q, occ_d;
   logic             pop;
   logic             becomes_single;

   assign pop = (occ_q != OccEmpty) & rd_ready;
   // After this cycle the only entry left is the one being written now.
   assign becomes_single = wr_en & ((occ_q == OccEmpty) | ((occ_q == OccOne) & pop));

   always_comb begin
      head_d      = pop ? ptr_inc(head_q) : head_q;
      tail_d      = wr_en ? ptr_inc(tail_q) : tail_q;
      occ_d       = occ_e'(2'(occ_q) + 2'(wr_en) - 2'(pop));
      head_data_d = head_data_q;
      if (occ_d != OccEmpty) begin
         head_data_d = becomes_single ? wr_data : mem_q[head_d];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q      <= 2'd0;
         tail_q      <= 2'd0;
         occ_q       <= OccEmpty;
         head_data_q <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         occ_q       <= occ_d;
         head_data_q <= head_data_d;
         if (wr_en) begin
            mem_q[tail_q] <= wr_data;
         end
      end
   end

   assign valid     = (occ_q != OccEmpty);
   assign head_data = head_data_q;
   assign occ       = occ_q;

endmodule

// File: rtl/enq_pkt_desc_deq.sv
// Read-side controller for the enqueue descriptor FIFO: credit-based pops, one-cycle
// read-latency absorption, valid/ready descriptor output and a hand-off counter.
module enq_pkt_desc_deq
   import meta_package::*;
#(
   parameter int unsigned DEPTH_NBITS = 12,
   parameter int unsigned BUF_DEPTH   = ENQ_DEQ_BUF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   deq_en,
   input  logic                   fifo_empty,
   input  logic [DEPTH_NBITS:0]   fifo_count,
   input  enq_pkt_desc_type       fifo_dout,
   output logic                   fifo_rd,
   output logic                   deq_valid,
   output enq_pkt_desc_type       deq_desc,
   input  logic                   deq_ready,
   output logic [1:0]             buf_occ,
   output logic [31:0]            deq_cnt
);

   logic        inflight_q;
   logic [31:0] deq_cnt_q;

   // Credit covers both buffered and in-flight entries, so a capture never overflows.
   assign fifo_rd = rst_n & deq_en & ~fifo_empty
                  & ((3'(buf_occ) + 3'(inflight_q)) < 3'(BUF_DEPTH));

   enq_pkt_desc_obuf u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (inflight_q),
      .wr_data   (fifo_dout),
      .rd_ready  (deq_ready),
      .valid     (deq_valid),
      .head_data (deq_desc),
      .occ       (buf_occ)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         deq_cnt_q  <= 32'd0;
      end else begin
         inflight_q <= fifo_rd;
         deq_cnt_q  <= deq_cnt_q + 32'(deq_valid & deq_ready);
      end
   end

   assign deq_cnt = deq_cnt_q;

`ifndef SYNTHESIS
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(inflight_q && (buf_occ == 2'(OccFull))));
   a_count_consistent : assert property (@(posedge clk) disable iff (!rst_n)
      !fifo_empty |-> (fifo_count != '0));
`endif

endmodule
